mem_wb_pipe: RTL
================

# mem_wb_pipe

Parametrised MEM/WB pipeline register for the processor datapath, sitting between the memory stage and the register-file write-back port. Carries ALU/memory result, destination address and write enable through `DEPTH` retimable stages for `LANES` parallel data lanes. Adds stall (hold), flush (bubble insertion), valid tracking, a retired-write counter and optional write-back forwarding to decode.

## Interface
Parameters:
- `DATA_W`, 32, width of one lane's result
- `ADDR_W`, 7, destination register address width
- `LANES`, 1, parallel data lanes (≥1)
- `DEPTH`, 1, number of register stages (≥1)
- `CNT_W`, 32, retire counter width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  entry from MEM stage is valid
- `in_data`  in  `LANES*DATA_W`  result, lane 0 in LSBs
- `in_addr`  in  `ADDR_W`  destination register
- `in_we`  in  1  entry writes register file
- `in_mask`  in  `LANES`  per-lane write mask
- `stall`  in  1  hold all stages
- `flush`  in  1  invalidate all stages
- `out_valid`  out  1  oldest stage valid
- `out_data`  out  `LANES*DATA_W`  oldest stage result
- `out_addr`  out  `ADDR_W`  oldest stage address
- `out_we`  out  1  write strobe to register file
- `out_mask`  out  `LANES`  oldest stage lane mask
- `retire_cnt`  out  `CNT_W`  count of committed writes
- `fwd_addr_a`, `fwd_addr_b`  in  `ADDR_W`  decode source addresses (macro only)
- `fwd_hit_a`, `fwd_hit_b`  out  1  full-mask match found (macro only)
- `fwd_part_a`, `fwd_part_b`  out  1  youngest match is partial-mask (macro only)
- `fwd_data_a`, `fwd_data_b`  out  `LANES*DATA_W`  forwarded data (macro only)

## Operation
- Stage 0 is youngest, stage `DEPTH-1` drives outputs. Each stage holds valid, data, addr, we, mask.
- Edge priority: flush > stall > advance.
- Flush: every stage valid and we cleared; data/addr/mask keep their values.
- Stall: all stages hold.
- Advance: stage 0 ← inputs (payload captured regardless of `in_valid`), stage k ← stage k-1.
- `out_valid` = stage valid; `out_we` = valid & we & ~stall (combinational on `stall`); data/addr/mask direct from stage.
- Commit: `out_valid & out_we` at a rising edge; `retire_cnt` increments by 1, wraps at 2^CNT_W. Commit happens even if `flush` is high that cycle (flush affects only next contents).
- `in_mask` = 0 with `in_we` = 1 is legal; counts as retired, writes nothing.

## Timing
- Reset (async, `rst_n` low): all stage fields zero; `out_valid`, `out_we`, `out_data`, `out_addr`, `out_mask`, `retire_cnt` = 0; forwarding outputs 0.
- Latency: input presented at edge N appears on outputs after edge N+DEPTH−1 … i.e. `DEPTH` edges without stall.
- Each stall cycle adds one cycle of latency; no entry lost or duplicated.
- Reset deasserted mid-stream: pipeline empty, first valid output `DEPTH` edges after first accepted input.
- Forwarding outputs are combinational from stage contents and `fwd_addr_*`; no added cycle.

## Configuration
- `MEMWB_FWD_EN` defined: forwarding logic and `fwd_*` ports present. For each source, scan stage 0 → `DEPTH-1`; first stage with valid & we & addr match decides: mask all-ones → hit=1, data=stage data, part=0; otherwise hit=0, part=1, data=0. No match → all 0. Address 0 is not special-cased.
- Undefined: `fwd_*` ports absent; no comparators synthesised.

## Structure
- Package `memwb_pkg`: default width constants (`MEMWB_DATA_W`, `MEMWB_ADDR_W`), stage-priority enum/constants for flush/stall/advance.
- Sub-module `memwb_stage`: one stage register (valid, we, data, addr, mask) with flush/hold/load controls, async reset; instantiated `DEPTH` times by generate.

## Test plan
- DEPTH=1: in 2/addr 1, then 9/addr 11, then 7/addr 5 on consecutive edges, we=1 → outputs follow one edge later, `retire_cnt` reaches 3.
- DEPTH=3: stream 1,2,3, stall 2 cycles after second input → output order 1,2,3, latency 3 plus 2 stall cycles, `retire_cnt`=3.
- Flush with stall high and 3 entries in flight → next cycle `out_valid`=0, all stages empty, `retire_cnt` counts only the entry committed before flush.
- `rst_n` pulled low mid-stream (DEPTH=2) → outputs and `retire_cnt` 0 immediately, without clock edge.
- CNT_W=4: 17 commits → `retire_cnt`=1.
- `MEMWB_FWD_EN`, LANES=2, DEPTH=2: stage0 addr 5 mask 01, stage1 addr 5 mask 11, fwd_addr_a=5 → `fwd_hit_a`=0, `fwd_part_a`=1; fwd_addr_b=9 unmatched → all 0.

Source files
------------

// File: rtl/memwb_pkg.sv
// memwb_pkg: shared constants and stage-control encoding for the MEM/WB pipe.
// Forwarding to decode is built only when MEMWB_FWD_EN is defined.
package memwb_pkg;

  localparam int MEMWB_DATA_W = 32;
  localparam int MEMWB_ADDR_W = 7;

  // Per-edge action applied uniformly to every stage; flush beats stall beats advance.
  typedef enum logic [1:0] {
    STG_ADVANCE = 2'd0,
    STG_STALL   = 2'd1,
    STG_FLUSH   = 2'd2
  } stage_op_e;

  function automatic stage_op_e stage_op(input logic flush, input logic stall);
    stage_op_e op;
    if (flush) begin
      op = STG_FLUSH;
    end else if (stall) begin
      op = STG_STALL;
    end else begin
      op = STG_ADVANCE;
    end
    return op;
  endfunction

endpackage

// File: rtl/memwb_stage.sv
// memwb_stage: one MEM/WB register slot (valid, we, data, addr, mask).
// Flush clears only the control bits; the payload is left untouched.
module memwb_stage
  import memwb_pkg::*;
#(
  parameter int DATA_W = MEMWB_DATA_W,
  parameter int ADDR_W = MEMWB_ADDR_W,
  parameter int LANES  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  stage_op_e               op,
  input  logic                    d_valid,
  input  logic                    d_we,
  input  logic [LANES*DATA_W-1:0] d_data,
  input  logic [ADDR_W-1:0]       d_addr,
  input  logic [LANES-1:0]        d_mask,
  output logic                    q_valid,
  output logic                    q_we,
  output logic [LANES*DATA_W-1:0] q_data,
  output logic [ADDR_W-1:0]       q_addr,
  output logic [LANES-1:0]        q_mask
);

  // Slot register: flush invalidates, stall holds, advance loads the upstream slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_we    <= 1'b0;
      q_data  <= '0;
      q_addr  <= '0;
      q_mask  <= '0;
    end else begin
      case (op)
        STG_FLUSH: begin
          q_valid <= 1'b0;
          q_we    <= 1'b0;
        end
        STG_STALL: begin
        end
        default: begin
          q_valid <= d_valid;
          q_we    <= d_we;
          q_data  <= d_data;
          q_addr  <= d_addr;
          q_mask  <= d_mask;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: DEPTH-stage MEM/WB register with stall, flush, retire counter.
// Define MEMWB_FWD_EN to add the write-back-to-decode forwarding ports and logic.
module mem_wb_pipe
  import memwb_pkg::*;
#(
  parameter int DATA_W = MEMWB_DATA_W,
  parameter int ADDR_W = MEMWB_ADDR_W,
  parameter int LANES  = 1,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0]       in_addr,
  input  logic                    in_we,
  input  logic [LANES-1:0]        in_mask,
  input  logic                    stall,
  input  logic                    flush,
`ifdef MEMWB_FWD_EN
  input  logic [ADDR_W-1:0]       fwd_addr_a,
  input  logic [ADDR_W-1:0]       fwd_addr_b,
  output logic                    fwd_hit_a,
  output logic                    fwd_hit_b,
  output logic                    fwd_part_a,
  output logic                    fwd_part_b,
  output logic [LANES*DATA_W-1:0] fwd_data_a,
  output logic [LANES*DATA_W-1:0] fwd_data_b,
`endif
  output logic                    out_valid,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0]       out_addr,
  output logic                    out_we,
  output logic [LANES-1:0]        out_mask,
  output logic [CNT_W-1:0]        retire_cnt
);

  stage_op_e                               op;
  logic [DEPTH-1:0]                        s_valid;
  logic [DEPTH-1:0]                        s_we;
  logic [DEPTH-1:0][LANES*DATA_W-1:0]      s_data;
  logic [DEPTH-1:0][ADDR_W-1:0]            s_addr;
  logic [DEPTH-1:0][LANES-1:0]             s_mask;

  assign op = stage_op(flush, stall);

  // Stage 0 takes the MEM-stage inputs, every later stage takes its predecessor.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      memwb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES)) u_stage (
        .clk(clk), .rst_n(rst_n), .op(op),
        .d_valid(in_valid), .d_we(in_we), .d_data(in_data),
        .d_addr(in_addr), .d_mask(in_mask),
        .q_valid(s_valid[gi]), .q_we(s_we[gi]), .q_data(s_data[gi]),
        .q_addr(s_addr[gi]), .q_mask(s_mask[gi])
      );
    end else begin : g_body
      memwb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES)) u_stage (
        .clk(clk), .rst_n(rst_n), .op(op),
        .d_valid(s_valid[gi-1]), .d_we(s_we[gi-1]), .d_data(s_data[gi-1]),
        .d_addr(s_addr[gi-1]), .d_mask(s_mask[gi-1]),
        .q_valid(s_valid[gi]), .q_we(s_we[gi]), .q_data(s_data[gi]),
        .q_addr(s_addr[gi]), .q_mask(s_mask[gi])
      );
    end
  end

  // The write strobe drops while stalled so a held entry is written exactly once.
  assign out_valid = s_valid[DEPTH-1];
  assign out_we    = s_valid[DEPTH-1] & s_we[DEPTH-1] & ~stall;
  assign out_data  = s_data[DEPTH-1];
  assign out_addr  = s_addr[DEPTH-1];
  assign out_mask  = s_mask[DEPTH-1];

  // Retire counter: one per committed write, wrapping naturally; flush does not block it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
    end else if (out_valid && out_we) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

`ifdef MEMWB_FWD_EN
  // Forwarding: youngest matching stage wins; a partial mask reports part and no data.
  always_comb begin
    fwd_hit_a  = 1'b0;
    fwd_part_a = 1'b0;
    fwd_data_a = '0;
    fwd_hit_b  = 1'b0;
    fwd_part_b = 1'b0;
    fwd_data_b = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (s_valid[i] && s_we[i] && (s_addr[i] == fwd_addr_a)) begin
        fwd_hit_a  = &s_mask[i];
        fwd_part_a = ~(&s_mask[i]);
        fwd_data_a = (&s_mask[i]) ? s_data[i] : '0;
      end
      if (s_valid[i] && s_we[i] && (s_addr[i] == fwd_addr_b)) begin
        fwd_hit_b  = &s_mask[i];
        fwd_part_b = ~(&s_mask[i]);
        fwd_data_b = (&s_mask[i]) ? s_data[i] : '0;
      end
    end
  end
`endif

endmodule
